// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: fetch sequencer states, next-PC select codes and reset address.
package pc_seq_pkg;
    typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} state_t;
    typedef enum logic [2:0] {SEL_SEQ, SEL_HOLD, SEL_BR, SEL_JR, SEL_J} sel_t;
    localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority mux choosing branch > jr > jump > stall > sequential.
module pc_next_sel import pc_seq_pkg::*; (
    input  logic [31:0] seq_pc,
    input  logic [31:0] hold_pc,
    input  logic        stall,
    input  logic        br,
    input  logic [31:0] br_tgt,
    input  logic        jr,
    input  logic [31:0] jr_tgt,
    input  logic        j,
    input  logic [31:0] j_tgt,
    output sel_t        sel,
    output logic [31:0] next_pc,
    output logic        misalign
);
    logic        redir;
    logic [31:0] tgt;
    always_comb begin
        redir    = br | jr | j;
        sel      = br ? SEL_BR : jr ? SEL_JR : j ? SEL_J : stall ? SEL_HOLD : SEL_SEQ;
        tgt      = br ? br_tgt : jr ? jr_tgt : j_tgt;
        misalign = redir && (tgt[1:0] != 2'b00);
        next_pc  = redir ? {tgt[31:2], 2'b00} : stall ? hold_pc : seq_pc;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with redirect/stall handling and flush pulses.
module pc_sequencer import pc_seq_pkg::*; #(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF,
    parameter logic [31:0] PC_INC     = 32'd4,
    parameter int          CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchTarget,
    input  logic             JumpReg,
    input  logic [31:0]      JumpRegTarget,
    input  logic             Jump,
    input  logic [31:0]      JumpTarget,
    output logic [31:0]      PCResult,
    output logic [31:0]      PCPlus4,
    output logic             FetchValid,
    output logic             FlushIF,
    output logic             FlushID,
    output logic             AlignErr,
    output logic [CNT_W-1:0] RedirectCount
);
    state_t      state;
    sel_t        sel;
    logic [31:0] next_pc;
    logic        misalign;
    logic        redirect;

    assign PCPlus4  = PCResult + PC_INC;
    assign redirect = (sel == SEL_BR) || (sel == SEL_JR) || (sel == SEL_J);

    pc_next_sel u_sel (
        .seq_pc(PCPlus4), .hold_pc(PCResult), .stall(Stall),
        .br(BranchTaken), .br_tgt(BranchTarget),
        .jr(JumpReg), .jr_tgt(JumpRegTarget),
        .j(Jump), .j_tgt(JumpTarget),
        .sel(sel), .next_pc(next_pc), .misalign(misalign)
    );

    // BOOT spends one cycle at RESET_ADDR with all requests ignored.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= BOOT;
            PCResult      <= RESET_ADDR;
            FetchValid    <= 1'b0;
            FlushIF       <= 1'b0;
            FlushID       <= 1'b0;
            AlignErr      <= 1'b0;
            RedirectCount <= '0;
        end else if (state == BOOT) begin
            state      <= RUN;
            FetchValid <= 1'b1;
        end else begin
            state    <= redirect ? FLUSH : (sel == SEL_HOLD) ? STALL : RUN;
            PCResult <= next_pc;
            FlushIF  <= redirect;
            FlushID  <= sel == SEL_BR;
            AlignErr <= AlignErr | misalign;
            if (redirect && RedirectCount != '1)
                RedirectCount <= RedirectCount + 1'b1;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven scoreboard bench for pc_sequencer with CNT_W=2.
module tb_pc_sequencer;
    localparam bit N = 1'b0;
    localparam bit Y = 1'b1;

    typedef struct {
        logic        stall, br;
        logic [31:0] brt;
        logic        jr;
        logic [31:0] jrt;
        logic        j;
        logic [31:0] jt;
        logic [31:0] pc;
        logic        fv, fif, fid, ae;
        logic [1:0]  cnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        fv, fif, fid, ae;
        logic [1:0]  cnt;
    } exp_t;

    logic        Clk = 1'b0, Reset = 1'b0;
    logic        Stall = 1'b0, BranchTaken = 1'b0, JumpReg = 1'b0, Jump = 1'b0;
    logic [31:0] BranchTarget = '0, JumpRegTarget = '0, JumpTarget = '0;
    logic [31:0] PCResult, PCPlus4;
    logic        FetchValid, FlushIF, FlushID, AlignErr;
    logic [1:0]  RedirectCount;

    int   checks = 0, fails = 0;
    exp_t sb[$];
    vec_t v[25];

    pc_sequencer #(.CNT_W(2)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .JumpReg(JumpReg), .JumpRegTarget(JumpRegTarget),
        .Jump(Jump), .JumpTarget(JumpTarget),
        .PCResult(PCResult), .PCPlus4(PCPlus4), .FetchValid(FetchValid),
        .FlushIF(FlushIF), .FlushID(FlushID), .AlignErr(AlignErr),
        .RedirectCount(RedirectCount)
    );

    always #5 Clk = ~Clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_front(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            cmp({tag, " scoreboard empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        cmp({tag, " PCResult"}, PCResult, e.pc);
        cmp({tag, " PCPlus4"}, PCPlus4, e.pc + 32'd4);
        cmp({tag, " FetchValid"}, {31'd0, FetchValid}, {31'd0, e.fv});
        cmp({tag, " FlushIF"}, {31'd0, FlushIF}, {31'd0, e.fif});
        cmp({tag, " FlushID"}, {31'd0, FlushID}, {31'd0, e.fid});
        cmp({tag, " AlignErr"}, {31'd0, AlignErr}, {31'd0, e.ae});
        cmp({tag, " RedirectCount"}, {30'd0, RedirectCount}, {30'd0, e.cnt});
    endtask

    task automatic push_reset_exp();
        sb.push_back('{pc: 32'h0, fv: N, fif: N, fid: N, ae: N, cnt: 2'd0});
    endtask

    task automatic apply(input int i);
        Stall         = v[i].stall;
        BranchTaken   = v[i].br;
        BranchTarget  = v[i].brt;
        JumpReg       = v[i].jr;
        JumpRegTarget = v[i].jrt;
        Jump          = v[i].j;
        JumpTarget    = v[i].jt;
        sb.push_back('{pc: v[i].pc, fv: v[i].fv, fif: v[i].fif, fid: v[i].fid,
                       ae: v[i].ae, cnt: v[i].cnt});
        @(posedge Clk);
        #1;
        check_front($sformatf("vec%0d", i));
    endtask

    task automatic do_reset(input string tag);
        {Stall, BranchTaken, JumpReg, Jump} = 4'b0;
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        push_reset_exp();
        check_front({tag, " in reset"});
        Reset = 1'b1;
        #1;
        push_reset_exp();
        check_front({tag, " boot"});
    endtask

    initial begin
        //        stall br  brt           jr  jrt           j   jt            pc            fv fif fid ae cnt
        v[0]  = '{N, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_0000, Y, N, N, N, 2'd0};
        v[1]  = '{N, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_0004, Y, N, N, N, 2'd0};
        v[2]  = '{N, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_0008, Y, N, N, N, 2'd0};
        v[3]  = '{N, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_000C, Y, N, N, N, 2'd0};
        v[4]  = '{N, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_0010, Y, N, N, N, 2'd0};
        v[5]  = '{Y, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_0010, Y, N, N, N, 2'd0};
        v[6]  = '{Y, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_0010, Y, N, N, N, 2'd0};
        v[7]  = '{N, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_0014, Y, N, N, N, 2'd0};
        v[8]  = '{N, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_0018, Y, N, N, N, 2'd0};
        v[9]  = '{N, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_001C, Y, N, N, N, 2'd0};
        v[10] = '{N, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_0020, Y, N, N, N, 2'd0};
        v[11] = '{Y, Y, 32'h100,      N, 32'h0,        N, 32'h0,        32'h0000_0100, Y, Y, Y, N, 2'd1};
        v[12] = '{N, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_0104, Y, N, N, N, 2'd1};
        v[13] = '{N, Y, 32'hC0,       Y, 32'h80,       Y, 32'h40,       32'h0000_00C0, Y, Y, Y, N, 2'd2};
        v[14] = '{N, N, 32'h0,        N, 32'h0,        Y, 32'h203,      32'h0000_0200, Y, Y, N, Y, 2'd3};
        v[15] = '{N, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_0204, Y, N, N, Y, 2'd3};
        v[16] = '{N, N, 32'h0,        Y, 32'hFFFF_FFF8, N, 32'h0,       32'hFFFF_FFF8, Y, Y, N, Y, 2'd3};
        v[17] = '{N, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'hFFFF_FFFC, Y, N, N, Y, 2'd3};
        v[18] = '{N, N, 32'h0,        N, 32'h0,        N, 32'h0,        32'h0000_0000, Y, N, N, Y, 2'd3};
        v[19] = '{N, N, 32'h0,        N, 32'h0,        Y, 32'h300,      32'h0000_0000, Y, N, N, N, 2'd0};
        v[20] = '{N, N, 32'h0,        N, 32'h0,        Y, 32'h300,      32'h0000_0300, Y, Y, N, N, 2'd1};
        v[21] = '{N, N, 32'h0,        Y, 32'h304,      N, 32'h0,        32'h0000_0304, Y, Y, N, N, 2'd2};
        v[22] = '{N, Y, 32'h308,      N, 32'h0,        N, 32'h0,        32'h0000_0308, Y, Y, Y, N, 2'd3};
        v[23] = '{N, N, 32'h0,        N, 32'h0,        Y, 32'h30C,      32'h0000_030C, Y, Y, N, N, 2'd3};
        v[24] = '{N, N, 32'h0,        Y, 32'h311,      N, 32'h0,        32'h0000_0310, Y, Y, N, Y, 2'd3};

        do_reset("reset1");
        for (int i = 0; i <= 18; i++) apply(i);

        do_reset("reset2");
        for (int i = 19; i <= 24; i++) apply(i);

        // Reset asserted while in FLUSH with a flush pulse pending: no clock edge needed.
        {Stall, BranchTaken, JumpReg, Jump} = 4'b0;
        Reset = 1'b0;
        #1;
        push_reset_exp();
        check_front("async reset mid-flush");
        @(posedge Clk);
        #1;
        push_reset_exp();
        check_front("held in reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
